// File: rtl/conv_bram_sr_chan_ctrl.sv
`default_nettype none
// =============================================================================
// Module : conv_bram_sr_chan_ctrl
// Brief  : Read-address sequencer and datapath controller for a convolution
//          engine fed from row-striped BRAMs through a column shift register.
// Rev    : 1.0
// =============================================================================
module conv_bram_sr_chan_ctrl #(
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int IMG_D    = 4,
  parameter int CH_PAR   = 1,
  parameter int FILTER_L = 3,
  parameter int FILTER_K = 8,
  parameter int STRIDE_W = 1,
  parameter int STRIDE_H = 1,
  localparam int RESULT_W = (IMG_W - FILTER_L) / STRIDE_W + 1,
  localparam int RESULT_H = (IMG_H - FILTER_L) / STRIDE_H + 1,
  localparam int NGRP     = IMG_D / CH_PAR,
  localparam int SAW      = $clog2(IMG_W * IMG_H / FILTER_L),
  localparam int GAW      = (NGRP > 1) ? $clog2(NGRP) : 1,
  localparam int RAW      = $clog2(RESULT_W * RESULT_H),
  localparam int ROTW     = $clog2(FILTER_L)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     val_in,
  output logic                     rdy_in,
  output logic [SAW*FILTER_L-1:0]  img_rdaddr,
  output logic [GAW-1:0]           img_ch_grp,
  output logic                     dpath_wren,
  output logic [ROTW-1:0]          dpath_rotation_offset,
  output logic                     dpath_sum_en,
  output logic                     dpath_acc_clr,
  output logic                     dpath_result_wren,
  output logic [RAW-1:0]           dpath_result_wraddr,
  input  logic                     res_rdy,
  input  logic                     last_val,
  output logic                     done
);

  localparam int FWW = $clog2(FILTER_L + 1);
  localparam int WW  = $clog2(RESULT_W + 1);
  localparam int HW  = $clog2(RESULT_H + 1);

  localparam logic [FWW-1:0] FW_START    = FWW'(FILTER_L - STRIDE_W);
  localparam logic [FWW-1:0] FW_LAST     = FWW'(FILTER_L - 1);
  localparam logic [FWW-1:0] FW_FILL_END = FWW'(FILTER_L - STRIDE_W - 1);
  localparam logic [WW-1:0]  W_LAST      = WW'(RESULT_W - 1);
  localparam logic [HW-1:0]  H_LAST      = HW'(RESULT_H - 1);
  localparam logic [GAW-1:0] G_LAST      = GAW'(NGRP - 1);
  localparam logic [SAW-1:0] IMG_W_T     = SAW'(IMG_W);

  // Vertical stride split into whole stripe-rows and a residual row offset.
  localparam int SH_DIV = STRIDE_H / FILTER_L;
  localparam int SH_MOD = STRIDE_H % FILTER_L;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_SLIDE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_ENTRY = (STRIDE_W == FILTER_L) ? S_SLIDE : S_FILL;

  logic [2:0]      r_state;
  logic [GAW-1:0]  r_g;
  logic [HW-1:0]   r_h;
  logic [WW-1:0]   r_w;
  logic [FWW-1:0]  r_fw;
  logic [ROTW-1:0] r_base_mod;   // (h*STRIDE_H) % FILTER_L
  logic [31:0]     r_row_addr;   // (h*STRIDE_H / FILTER_L) * IMG_W
  logic [31:0]     r_col_base;   // w*STRIDE_W
  logic [31:0]     r_res_base;   // h*RESULT_W

  logic            r_wren_d1;
  logic [ROTW-1:0] r_rot_d1;
  logic            r_sum_d1;
  logic            r_first_d1;
  logic            r_last_d1;
  logic [RAW-1:0]  r_raddr_d1;
  logic            r_sum_d2;
  logic            r_clr_d2;
  logic            r_rwr_d2;
  logic [RAW-1:0]  r_raddr_d2;

  logic            w_fw_last;
  logic            w_stall;
  logic            w_issue;
  logic            w_sum;
  logic [31:0]     w_mod_sum;
  logic            w_mod_wrap;
  logic [ROTW-1:0] w_next_mod;
  logic [31:0]     w_next_row_addr;
  logic [31:0]     w_col_addr;
  logic [31:0]     w_res_full;
  logic            w_unused;

  assign w_fw_last = (r_fw == FW_LAST);
  assign w_stall   = (r_state == S_SLIDE) && w_fw_last && !res_rdy;
  assign w_issue   = (r_state == S_FILL) || ((r_state == S_SLIDE) && !w_stall);
  assign w_sum     = (r_state == S_SLIDE) && w_fw_last && res_rdy;

  assign w_mod_sum       = 32'(r_base_mod) + 32'(SH_MOD);
  assign w_mod_wrap      = (w_mod_sum >= 32'(FILTER_L));
  assign w_next_mod      = ROTW'(w_mod_wrap ? (w_mod_sum - 32'(FILTER_L)) : w_mod_sum);
  assign w_next_row_addr = r_row_addr + 32'(SH_DIV * IMG_W)
                         + (w_mod_wrap ? 32'(IMG_W) : 32'd0);

  assign w_col_addr = r_row_addr + r_col_base + 32'(r_fw);
  assign w_res_full = r_res_base + 32'(r_w);

  // Stripes below the base row's stripe hold window rows already in the next
  // stripe-row. Truncated addition is exact on the retained low bits.
  for (genvar s = 0; s < FILTER_L; s++) begin : g_stripe
    assign img_rdaddr[s*SAW +: SAW] = w_col_addr[SAW-1:0]
                                    + ((32'(s) < 32'(r_base_mod)) ? IMG_W_T : '0);
  end

  assign w_unused = ^{w_col_addr[31:SAW], w_res_full[31:RAW], 32'(FILTER_K)};

  assign img_ch_grp            = r_g;
  assign rdy_in                = (r_state == S_IDLE);
  assign done                  = (r_state == S_WAIT) && last_val;
  assign dpath_wren            = r_wren_d1;
  assign dpath_rotation_offset = r_rot_d1;
  assign dpath_sum_en          = r_sum_d2;
  assign dpath_acc_clr         = r_clr_d2;
  assign dpath_result_wren     = r_rwr_d2;
  assign dpath_result_wraddr   = r_raddr_d2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_g        <= '0;
      r_h        <= '0;
      r_w        <= '0;
      r_fw       <= '0;
      r_base_mod <= '0;
      r_row_addr <= '0;
      r_col_base <= '0;
      r_res_base <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (val_in) begin
            r_state    <= S_ENTRY;
            r_g        <= '0;
            r_h        <= '0;
            r_w        <= '0;
            r_fw       <= '0;
            r_base_mod <= '0;
            r_row_addr <= '0;
            r_col_base <= '0;
            r_res_base <= '0;
          end
        end
        S_FILL: begin
          r_fw <= r_fw + FWW'(1);
          if (r_fw == FW_FILL_END) r_state <= S_SLIDE;
        end
        S_SLIDE: begin
          if (w_fw_last) begin
            if (res_rdy) begin
              r_fw       <= FW_START;
              r_w        <= r_w + WW'(1);
              r_col_base <= r_col_base + 32'(STRIDE_W);
              if (r_w == W_LAST) r_state <= S_CHECK;
            end
          end else begin
            r_fw <= r_fw + FWW'(1);
          end
        end
        S_CHECK: begin
          r_w        <= '0;
          r_fw       <= '0;
          r_col_base <= '0;
          if (r_h < H_LAST) begin
            r_h        <= r_h + HW'(1);
            r_res_base <= r_res_base + 32'(RESULT_W);
            r_base_mod <= w_next_mod;
            r_row_addr <= w_next_row_addr;
            r_state    <= S_ENTRY;
          end else if (r_g < G_LAST) begin
            r_g        <= r_g + GAW'(1);
            r_h        <= '0;
            r_res_base <= '0;
            r_base_mod <= '0;
            r_row_addr <= '0;
            r_state    <= S_ENTRY;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (last_val) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write/rotation at t+1, sum and its qualifiers at t+2.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wren_d1  <= 1'b0;
      r_rot_d1   <= '0;
      r_sum_d1   <= 1'b0;
      r_first_d1 <= 1'b0;
      r_last_d1  <= 1'b0;
      r_raddr_d1 <= '0;
      r_sum_d2   <= 1'b0;
      r_clr_d2   <= 1'b0;
      r_rwr_d2   <= 1'b0;
      r_raddr_d2 <= '0;
    end else begin
      r_wren_d1  <= w_issue;
      r_rot_d1   <= r_base_mod;
      r_sum_d1   <= w_sum;
      r_first_d1 <= (r_g == '0);
      r_last_d1  <= (r_g == G_LAST);
      r_raddr_d1 <= w_res_full[RAW-1:0];
      r_sum_d2   <= r_sum_d1;
      r_clr_d2   <= r_sum_d1 && r_first_d1;
      r_rwr_d2   <= r_sum_d1 && r_last_d1;
      r_raddr_d2 <= r_raddr_d1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_bram_sr_chan_ctrl.sv
`default_nettype none
// =============================================================================
// Module : tb_conv_bram_sr_chan_ctrl
// Brief  : Directed self-checking bench for conv_bram_sr_chan_ctrl.
// Rev    : 1.0
// =============================================================================
module tb_conv_bram_sr_chan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, res_rdy, last_val, val_a, val_b, val_c;

  // A: 5x5x2, F3, stride 1
  logic        rdy_a, wren_a, sum_a, clr_a, rwr_a, done_a;
  logic [8:0]  addr_a;
  logic [0:0]  grp_a;
  logic [1:0]  rot_a;
  logic [3:0]  raddr_a;
  // B: 7x7x1, F3, stride 2
  logic        rdy_b, wren_b, sum_b, clr_b, rwr_b, done_b;
  logic [11:0] addr_b;
  logic [0:0]  grp_b;
  logic [1:0]  rot_b;
  logic [3:0]  raddr_b;
  // C: 6x6x1, F3, stride 1
  logic        rdy_c, wren_c, sum_c, clr_c, rwr_c, done_c;
  logic [11:0] addr_c;
  logic [0:0]  grp_c;
  logic [1:0]  rot_c;
  logic [3:0]  raddr_c;

  conv_bram_sr_chan_ctrl #(.IMG_W(5), .IMG_H(5), .IMG_D(2), .CH_PAR(1), .FILTER_L(3),
                           .FILTER_K(8), .STRIDE_W(1), .STRIDE_H(1)) u_dut_a (
    .clk(clk), .reset(reset), .val_in(val_a), .rdy_in(rdy_a), .img_rdaddr(addr_a),
    .img_ch_grp(grp_a), .dpath_wren(wren_a), .dpath_rotation_offset(rot_a),
    .dpath_sum_en(sum_a), .dpath_acc_clr(clr_a), .dpath_result_wren(rwr_a),
    .dpath_result_wraddr(raddr_a), .res_rdy(res_rdy), .last_val(last_val), .done(done_a));

  conv_bram_sr_chan_ctrl #(.IMG_W(7), .IMG_H(7), .IMG_D(1), .CH_PAR(1), .FILTER_L(3),
                           .FILTER_K(8), .STRIDE_W(2), .STRIDE_H(2)) u_dut_b (
    .clk(clk), .reset(reset), .val_in(val_b), .rdy_in(rdy_b), .img_rdaddr(addr_b),
    .img_ch_grp(grp_b), .dpath_wren(wren_b), .dpath_rotation_offset(rot_b),
    .dpath_sum_en(sum_b), .dpath_acc_clr(clr_b), .dpath_result_wren(rwr_b),
    .dpath_result_wraddr(raddr_b), .res_rdy(res_rdy), .last_val(last_val), .done(done_b));

  conv_bram_sr_chan_ctrl #(.IMG_W(6), .IMG_H(6), .IMG_D(1), .CH_PAR(1), .FILTER_L(3),
                           .FILTER_K(8), .STRIDE_W(1), .STRIDE_H(1)) u_dut_c (
    .clk(clk), .reset(reset), .val_in(val_c), .rdy_in(rdy_c), .img_rdaddr(addr_c),
    .img_ch_grp(grp_c), .dpath_wren(wren_c), .dpath_rotation_offset(rot_c),
    .dpath_sum_en(sum_c), .dpath_acc_clr(clr_c), .dpath_result_wren(rwr_c),
    .dpath_result_wraddr(raddr_c), .res_rdy(res_rdy), .last_val(last_val), .done(done_c));

  int n_total = 0;
  int n_pass  = 0;

  int a_wren, a_sum, a_clr, a_rwr, a_order_err;
  int b_wren, b_sum, b_rwr, b_order_err, b_rot_seq, b_rot_n;
  logic [1:0]  b_rot_last;
  int c_hit;
  logic [11:0] c_prev_addr, c_hit_addr;
  logic [0:0]  c_prev_grp, c_hit_grp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_counts();
    a_wren = 0; a_sum = 0; a_clr = 0; a_rwr = 0; a_order_err = 0;
    b_wren = 0; b_sum = 0; b_rwr = 0; b_order_err = 0; b_rot_seq = 0; b_rot_n = 0;
    b_rot_last = '0;
    c_hit = 0; c_prev_addr = '0; c_hit_addr = '0; c_prev_grp = '0; c_hit_grp = '0;
  endtask

  // Advance one cycle and sample every instance just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wren_a) a_wren++;
    if (sum_a) a_sum++;
    if (clr_a) begin
      if (raddr_a != 4'(a_clr % 9)) a_order_err++;
      a_clr++;
    end
    if (rwr_a) begin
      if (raddr_a != 4'(a_rwr % 9)) a_order_err++;
      a_rwr++;
    end
    if (wren_b) begin
      b_wren++;
      if (b_rot_n == 0 || rot_b != b_rot_last) begin
        b_rot_seq  = b_rot_seq * 4 + int'(rot_b);
        b_rot_n++;
        b_rot_last = rot_b;
      end
    end
    if (sum_b) b_sum++;
    if (rwr_b) begin
      if (raddr_b != 4'(b_rwr)) b_order_err++;
      b_rwr++;
    end
    // First write of output row 1 exposes the address issued the cycle before.
    if (wren_c && rot_c == 2'd1 && c_hit == 0) begin
      c_hit      = 1;
      c_hit_addr = c_prev_addr;
      c_hit_grp  = c_prev_grp;
    end
    c_prev_addr = addr_c;
    c_prev_grp  = grp_c;
  endtask

  task automatic check_a_totals(input string tag);
    chk({tag, "_wren"},  a_wren, 30);
    chk({tag, "_sum"},   a_sum, 18);
    chk({tag, "_clr"},   a_clr, 9);
    chk({tag, "_rwr"},   a_rwr, 9);
    chk({tag, "_order"}, a_order_err, 0);
    chk({tag, "_wait_rdy"}, rdy_a, 0);
    chk({tag, "_no_early_done"}, done_a, 0);
  endtask

  task automatic finish_a(input string tag);
    last_val = 1'b1;
    #1;
    chk({tag, "_done"}, done_a, 1);
    tick();
    last_val = 1'b0;
    #1;
    chk({tag, "_idle_rdy"}, rdy_a, 1);
    chk({tag, "_done_pulse"}, done_a, 0);
  endtask

  initial begin
    reset = 1'b0; res_rdy = 1'b1; last_val = 1'b0;
    val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
    clear_counts();
    tick();
    tick();
    chk("rst_rdy",  rdy_a, 1);
    chk("rst_wren", wren_a, 0);
    chk("rst_sum",  sum_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_rot",  rot_a, 0);
    chk("rst_done", done_a, 0);
    reset = 1'b1;
    tick();

    // Nominal two-group run
    clear_counts();
    val_a = 1'b1;
    tick();
    val_a = 1'b0;
    chk("nom_busy_rdy", rdy_a, 0);
    repeat (50) tick();
    check_a_totals("nom");
    finish_a("nom");

    // Backpressure at the first completion cycle (h=0,w=0,fw=2: all stripes at 2)
    clear_counts();
    val_a = 1'b1;
    tick();
    val_a = 1'b0;
    tick();
    tick();
    chk("bp_pre_addr", addr_a, 9'h092);
    res_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_wren", wren_a, 0);
      chk("bp_sum",  sum_a, 0);
      chk("bp_addr", addr_a, 9'h092);
    end
    res_rdy = 1'b1;
    repeat (50) tick();
    check_a_totals("bp");
    finish_a("bp");

    // Reset while a sum is in flight in SLIDE
    clear_counts();
    val_a = 1'b1;
    tick();
    val_a = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_rdy",  rdy_a, 1);
    chk("mid_rst_sum",  sum_a, 0);
    chk("mid_rst_wren", wren_a, 0);
    chk("mid_rst_addr", addr_a, 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_sum2", sum_a, 0);
    chk("mid_rst_rdy2", rdy_a, 1);
    clear_counts();
    val_a = 1'b1;
    tick();
    val_a = 1'b0;
    repeat (50) tick();
    check_a_totals("restart");
    finish_a("restart");

    // Stride 2 on 7x7
    clear_counts();
    val_b = 1'b1;
    tick();
    val_b = 1'b0;
    repeat (50) tick();
    chk("str_wren",    b_wren, 21);
    chk("str_sum",     b_sum, 9);
    chk("str_rwr",     b_rwr, 9);
    chk("str_order",   b_order_err, 0);
    chk("str_rot_n",   b_rot_n, 3);
    chk("str_rot_seq", b_rot_seq, 9);
    last_val = 1'b1;
    #1;
    chk("str_done", done_b, 1);
    tick();
    last_val = 1'b0;

    // Stripe routing on 6x6 at h=1,w=0,fw=0: stripes {2,1,0} = {0,0,6}
    clear_counts();
    val_c = 1'b1;
    tick();
    val_c = 1'b0;
    repeat (30) tick();
    chk("addr_found", c_hit, 1);
    chk("addr_val",   c_hit_addr, 12'h006);
    chk("addr_grp",   c_hit_grp, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
